// File: rtl/ivalu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : ivalu_issue_queue
// Purpose  : Collapsing issue queue for the packed-SIMD integer ALU. Tracks
//            source readiness via writeback-tag wakeup and selects the oldest
//            ready micro-op. It reads the operands and presents a registered
//            bundle to the ALU.
// Options  : IVALU_IQ_PERF_EN adds the perf_issue_cnt_o / perf_full_cnt_o
//            counters.
// Revision : 1.0 - initial release
// ============================================================================
module ivalu_issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic        core_clock_i,
  input  logic        core_reset_i,
  input  logic        flush_i,
  input  logic        disp_valid_i,
  input  logic [6:0]  disp_op_i,
  input  logic [4:0]  disp_rob_i,
  input  logic [5:0]  disp_dest_i,
  input  logic [5:0]  disp_src_a_i,
  input  logic [5:0]  disp_src_b_i,
  input  logic        disp_rdy_a_i,
  input  logic        disp_rdy_b_i,
  output logic        disp_ready_o,
  input  logic [1:0]  wk_valid_i,
  input  logic [11:0] wk_tag_i,
  output logic [5:0]  rf_raddr_a_o,
  output logic [5:0]  rf_raddr_b_o,
  input  logic [31:0] rf_rdata_a_i,
  input  logic [31:0] rf_rdata_b_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [6:0]  op_o,
  output logic [4:0]  rob_o,
  output logic [5:0]  dest_o,
`ifdef IVALU_IQ_PERF_EN
  output logic [31:0] perf_issue_cnt_o,
  output logic [31:0] perf_full_cnt_o,
`endif
  output logic        valid_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rob;
    logic [5:0] dest;
    logic [5:0] src_a;
    logic [5:0] src_b;
    logic       rdy_a;
    logic       rdy_b;
  } entry_t;

  // Slot i holds a live op only when i < count; stale slots are never selected.
  entry_t             entries     [DEPTH];
  entry_t             shifted     [DEPTH];
  entry_t             entries_nxt [DEPTH];
  entry_t             disp_entry;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   wr_idx;
  logic               disp_acc;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;

  // Tag 0 is the hardwired always-available register.
  function automatic logic tag_hit(input logic [5:0] tag, input logic [1:0] v,
                                   input logic [11:0] t);
    tag_hit = (tag == 6'd0) || (v[0] && (t[5:0] == tag)) || (v[1] && (t[11:6] == tag));
  endfunction

  assign disp_ready_o = (count < CNT_W'(DEPTH));
  assign rf_raddr_a_o = sel_found ? entries[sel_idx].src_a : 6'd0;
  assign rf_raddr_b_o = sel_found ? entries[sel_idx].src_b : 6'd0;

  // Oldest-first select: scan downwards so the lowest ready index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < count) && entries[i].rdy_a && entries[i].rdy_b) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Collapse over the issued slot, wake in post-shift slots, then append the dispatch.
  always_comb begin
    disp_acc         = disp_valid_i && disp_ready_o && !flush_i;
    wr_idx           = count - CNT_W'(sel_found);
    disp_entry.op    = disp_op_i;
    disp_entry.rob   = disp_rob_i;
    disp_entry.dest  = disp_dest_i;
    disp_entry.src_a = disp_src_a_i;
    disp_entry.src_b = disp_src_b_i;
    disp_entry.rdy_a = disp_rdy_a_i | tag_hit(disp_src_a_i, wk_valid_i, wk_tag_i);
    disp_entry.rdy_b = disp_rdy_b_i | tag_hit(disp_src_b_i, wk_valid_i, wk_tag_i);
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = (sel_found && (IDX_W'(i) >= sel_idx)) ? entries[i+1] : entries[i];
    end
    shifted[DEPTH-1] = sel_found ? '0 : entries[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      entries_nxt[i]       = shifted[i];
      entries_nxt[i].rdy_a = shifted[i].rdy_a | tag_hit(shifted[i].src_a, wk_valid_i, wk_tag_i);
      entries_nxt[i].rdy_b = shifted[i].rdy_b | tag_hit(shifted[i].src_b, wk_valid_i, wk_tag_i);
      if (disp_acc && (CNT_W'(i) == wr_idx)) begin
        entries_nxt[i] = disp_entry;
      end
    end
  end

  // Queue storage and occupancy; reset and flush both empty the queue.
  always_ff @(posedge core_clock_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] <= entries_nxt[i];
    end
    if (core_reset_i || flush_i) begin
      count <= '0;
    end else begin
      count <= count - CNT_W'(sel_found) + CNT_W'(disp_acc);
    end
  end

  // Registered ALU bundle; data fields hold when nothing is selected.
  always_ff @(posedge core_clock_i) begin
    if (core_reset_i) begin
      valid_o <= 1'b0;
      a_o     <= '0;
      b_o     <= '0;
      op_o    <= '0;
      rob_o   <= '0;
      dest_o  <= '0;
    end else begin
      valid_o <= sel_found && !flush_i;
      if (sel_found) begin
        a_o    <= rf_rdata_a_i;
        b_o    <= rf_rdata_b_i;
        op_o   <= entries[sel_idx].op;
        rob_o  <= entries[sel_idx].rob;
        dest_o <= entries[sel_idx].dest;
      end
    end
  end

`ifdef IVALU_IQ_PERF_EN
  // Free-running event counters; cleared by reset only, not by flush.
  always_ff @(posedge core_clock_i) begin
    if (core_reset_i) begin
      perf_issue_cnt_o <= '0;
      perf_full_cnt_o  <= '0;
    end else begin
      perf_issue_cnt_o <= perf_issue_cnt_o + 32'(valid_o);
      perf_full_cnt_o  <= perf_full_cnt_o + 32'(disp_valid_i && !disp_ready_o);
    end
  end
`endif

endmodule
`default_nettype wire
